// File: rtl/spi_sensor_pkg.sv
// Shared types and default register map for the SPI sensor poller.
package spi_sensor_pkg;

    localparam int unsigned NUM_BYTES  = 6;
    localparam int unsigned BYTE_IDX_W = 3;

    localparam logic [5:0] DEF_INIT_ADDR  = 6'h2D;
    localparam logic [7:0] DEF_INIT_DATA  = 8'h08;
    localparam logic [5:0] DEF_DATA_ADDR  = 6'h32;
    localparam logic [5:0] DEF_DEVID_ADDR = 6'h00;
    localparam logic [7:0] DEF_DEVID_VAL  = 8'hE5;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_CHECK_ID,
        ST_INIT_WR,
        ST_PERIOD,
        ST_RD,
        ST_EMIT,
        ST_HALT
    } main_state_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_ISSUE,
        XF_DONE
    } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// Single SPI transaction handshake: busy synchroniser, request/response phases, per-phase timeout.
module spi_xfer_ctrl
    import spi_sensor_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req_rw,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [7:0] spi_rdata,
    input  logic       spi_busy,
    output logic       spi_en,
    output logic       spi_rw,
    output logic [5:0] spi_address,
    output logic [7:0] spi_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       timeout,
    output logic       busy
);

    localparam int unsigned TMO_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    xfer_state_e      state_q, state_d;
    logic             en_q, en_d;
    logic             rw_q, rw_d;
    logic [5:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             tmo_expired;

    assign tmo_expired = (tmo_q == TMO_W'(BUSY_TIMEOUT - 1));

    // Next-state logic for the handshake and the busy synchroniser.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        tmo_d     = tmo_q;
        sync1_d   = spi_busy;
        sync2_d   = sync1_q;

        case (state_q)
            XF_IDLE: begin
                if (start) begin
                    rw_d    = req_rw;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    en_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = XF_ISSUE;
                end
            end
            XF_ISSUE: begin
                if (sync2_q) begin
                    en_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = XF_DONE;
                end else if (tmo_expired) begin
                    en_d      = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = XF_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            XF_DONE: begin
                if (!sync2_q) begin
                    if (rw_q) begin
                        rdata_d = spi_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = XF_IDLE;
                end else if (tmo_expired) begin
                    timeout_d = 1'b1;
                    state_d   = XF_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = XF_IDLE;
            end
        endcase
    end

    // State register; synchroniser resets to "busy" so nothing issues before the real level is known.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= XF_IDLE;
            en_q      <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            tmo_q     <= '0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            tmo_q     <= tmo_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign spi_en      = en_q;
    assign spi_rw      = rw_q;
    assign spi_address = addr_q;
    assign spi_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign busy        = sync2_q;

endmodule

// File: rtl/spi_sensor_poller.sv
// SPI sensor poller: init write, periodic 6-byte burst read, X/Y/Z sample assembly.
// Optional build macro DEVID_CHECK_EN adds a device-ID read ahead of the init write.
module spi_sensor_poller
    import spi_sensor_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter logic [5:0]  INIT_ADDR     = DEF_INIT_ADDR,
    parameter logic [7:0]  INIT_DATA     = DEF_INIT_DATA,
    parameter logic [5:0]  DATA_ADDR     = DEF_DATA_ADDR,
    parameter int unsigned BUSY_TIMEOUT  = 4096
`ifdef DEVID_CHECK_EN
    ,
    parameter logic [5:0]  DEVID_ADDR    = DEF_DEVID_ADDR,
    parameter logic [7:0]  DEVID_VAL     = DEF_DEVID_VAL
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        spi_en,
    output logic        spi_rw,
    output logic [5:0]  spi_address,
    output logic [7:0]  spi_wdata,
    input  logic [7:0]  spi_rdata,
    input  logic        spi_busy,
    output logic [15:0] sample_x,
    output logic [15:0] sample_y,
    output logic [15:0] sample_z,
    output logic        sample_valid,
    output logic        overrun,
    output logic        error
);

    localparam int unsigned CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

    main_state_e                    state_q, state_d;
    logic [BYTE_IDX_W-1:0]          rd_idx_q, rd_idx_d;
    logic                           issued_q, issued_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           pending_q, pending_d;
    logic                           overrun_q, overrun_d;
    logic                           error_q, error_d;
    logic [NUM_BYTES-1:0][7:0]      bytes_q, bytes_d;
    logic [15:0]                    sample_x_q, sample_x_d;
    logic [15:0]                    sample_y_q, sample_y_d;
    logic [15:0]                    sample_z_q, sample_z_d;
    logic                           valid_q, valid_d;

    logic                           start_c;
    logic                           start_seq_c;
    logic                           req_rw_c;
    logic [5:0]                     req_addr_c;
    logic [7:0]                     req_wdata_c;
    logic                           tc_c;
    logic [7:0]                     x_rdata;
    logic                           x_done;
    logic                           x_timeout;
    logic                           x_busy;

    assign tc_c = (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));

    spi_xfer_ctrl #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_xfer (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .req_rw      (req_rw_c),
        .req_addr    (req_addr_c),
        .req_wdata   (req_wdata_c),
        .spi_rdata   (spi_rdata),
        .spi_busy    (spi_busy),
        .spi_en      (spi_en),
        .spi_rw      (spi_rw),
        .spi_address (spi_address),
        .spi_wdata   (spi_wdata),
        .rdata       (x_rdata),
        .done        (x_done),
        .timeout     (x_timeout),
        .busy        (x_busy)
    );

    // Main sequencer, period counter and sample assembly.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        issued_d    = issued_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        error_d     = error_q;
        bytes_d     = bytes_q;
        sample_x_d  = sample_x_q;
        sample_y_d  = sample_y_q;
        sample_z_d  = sample_z_q;
        valid_d     = 1'b0;
        start_c     = 1'b0;
        start_seq_c = 1'b0;
        req_rw_c    = 1'b1;
        req_addr_c  = DATA_ADDR + 6'(rd_idx_q);
        req_wdata_c = 8'h00;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (!x_busy) begin
`ifdef DEVID_CHECK_EN
                    state_d = ST_CHECK_ID;
`else
                    state_d = ST_INIT_WR;
`endif
                end
            end
`ifdef DEVID_CHECK_EN
            ST_CHECK_ID: begin
                req_addr_c = DEVID_ADDR;
                start_c    = !issued_q;
                issued_d   = 1'b1;
                if (x_timeout) begin
                    issued_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_HALT;
                end else if (x_done) begin
                    issued_d = 1'b0;
                    if (x_rdata == DEVID_VAL) begin
                        state_d = ST_INIT_WR;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end
`endif
            ST_INIT_WR: begin
                req_rw_c    = 1'b0;
                req_addr_c  = INIT_ADDR;
                req_wdata_c = INIT_DATA;
                start_c     = !issued_q;
                issued_d    = 1'b1;
                if (x_timeout) begin
                    issued_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_HALT;
                end else if (x_done) begin
                    issued_d = 1'b0;
                    state_d  = ST_PERIOD;
                end
            end
            ST_PERIOD: begin
                if (tc_c && enable) begin
                    rd_idx_d    = '0;
                    start_seq_c = 1'b1;
                    state_d     = ST_RD;
                end
            end
            ST_RD: begin
                start_c  = !issued_q;
                issued_d = 1'b1;
                // Next start is already due: remember it so EMIT chains straight into it.
                if (tc_c) begin
                    overrun_d = 1'b1;
                    pending_d = 1'b1;
                end
                if (x_timeout) begin
                    issued_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_HALT;
                end else if (x_done) begin
                    issued_d          = 1'b0;
                    bytes_d[rd_idx_q] = x_rdata;
                    if (rd_idx_q == BYTE_IDX_W'(NUM_BYTES - 1)) begin
                        state_d = ST_EMIT;
                    end else begin
                        rd_idx_d = rd_idx_q + BYTE_IDX_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                sample_x_d = {bytes_q[1], bytes_q[0]};
                sample_y_d = {bytes_q[3], bytes_q[2]};
                sample_z_d = {bytes_q[5], bytes_q[4]};
                valid_d    = 1'b1;
                pending_d  = 1'b0;
                if ((pending_q || tc_c) && enable) begin
                    rd_idx_d    = '0;
                    start_seq_c = 1'b1;
                    state_d     = ST_RD;
                end else begin
                    state_d = ST_PERIOD;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Period counter restarts at every sequence start and wraps free otherwise.
        if (state_q inside {ST_PERIOD, ST_RD, ST_EMIT}) begin
            cnt_d = (start_seq_c || tc_c) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT_IDLE;
            rd_idx_q   <= '0;
            issued_q   <= 1'b0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            error_q    <= 1'b0;
            bytes_q    <= '0;
            sample_x_q <= '0;
            sample_y_q <= '0;
            sample_z_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            issued_q   <= issued_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            error_q    <= error_d;
            bytes_q    <= bytes_d;
            sample_x_q <= sample_x_d;
            sample_y_q <= sample_y_d;
            sample_z_q <= sample_z_d;
            valid_q    <= valid_d;
        end
    end

    assign sample_x     = sample_x_q;
    assign sample_y     = sample_y_q;
    assign sample_z     = sample_z_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign error        = error_q;

endmodule
